// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for alu_seq.
// ALU_DIV_EN adds DIVU/REMU to the set of iterative operations.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_RSV3  = 4'b0011;
    localparam logic [3:0] OP_ANDN  = 4'b0100;
    localparam logic [3:0] OP_ORN   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op_is_iter(input logic [3:0] op);
`ifdef ALU_DIV_EN
        return (op[3:2] == 2'b10);
`else
        return (op[3:1] == 3'b100);
`endif
    endfunction

    // Without the divider no iterative op has op[1] set, so this folds to 0.
    function automatic logic op_is_div(input logic [3:0] op);
        return op_is_iter(op) & op[1];
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Valid/ready operand and result bus of alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, dz
    );

endinterface

// File: rtl/alu_core.sv
// Combinational legacy ALU on the 3-bit function code; also the add/subtract
// step of the iterative multiplier and divider.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    // Function decode; code 011 is reserved and yields zero.
    always_comb begin
        y_o = {WIDTH{1'b0}};
        case (func_i)
            3'b000:  y_o = a_i & b_i;
            3'b001:  y_o = a_i | b_i;
            3'b010:  y_o = a_i + b_i;
            3'b100:  y_o = a_i & ~b_i;
            3'b101:  y_o = a_i | ~b_i;
            3'b110:  y_o = a_i - b_i;
            3'b111:  y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: y_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-pass legacy ops plus iterative shift-add multiply and,
// with ALU_DIV_EN defined, restoring divide. All result outputs are registered.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset_n,
    alu_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;

    logic             accept_s;
    logic [2:0]       func_s;
    logic [WIDTH-1:0] core_a_s, core_b_s, core_y_s;
    logic [WIDTH-1:0] mul_hi_s, mul_lo_s, hi_n_s, lo_n_s;
    logic             carry_s;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] rsh_s;

    // Partial remainder shifted left with the next dividend bit (from a_q's MSB).
    assign rsh_s = {hi_q[WIDTH-2:0], a_q[WIDTH-1]};
`endif

    assign accept_s      = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.dz        = dz_q;

    // Core operand select: bus operands when accepting, iteration step during RUN.
    always_comb begin
        func_s   = bus.op[2:0];
        core_a_s = bus.a;
        core_b_s = bus.b;
        if (state_q == ST_RUN) begin
            core_b_s = b_q;
`ifdef ALU_DIV_EN
            if (op_q[1]) begin
                func_s   = 3'b110;
                core_a_s = rsh_s;
            end else begin
                func_s   = 3'b010;
                core_a_s = hi_q;
            end
`else
            func_s   = 3'b010;
            core_a_s = hi_q;
`endif
        end else begin
            func_s   = bus.op[2:0];
            core_a_s = bus.a;
            core_b_s = bus.b;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .func_i (func_s),
        .a_i    (core_a_s),
        .b_i    (core_b_s),
        .y_o    (core_y_s)
    );

    // Shift-add step: {hi,lo} accumulates the product, a_q holds the shrinking multiplier.
    always_comb begin
        carry_s = (core_y_s < hi_q);
        if (a_q[0]) begin
            mul_hi_s = {carry_s, core_y_s[WIDTH-1:1]};
            mul_lo_s = {core_y_s[0], a_q[WIDTH-1:1]};
        end else begin
            mul_hi_s = {1'b0, hi_q[WIDTH-1:1]};
            mul_lo_s = {hi_q[0], a_q[WIDTH-1:1]};
        end
    end

    // Select the step result; a divisor of zero always "fits", giving all-ones quotient.
    always_comb begin
`ifdef ALU_DIV_EN
        if (op_q[1]) begin
            if (hi_q[WIDTH-1] || (rsh_s >= b_q)) begin
                hi_n_s = core_y_s;
                lo_n_s = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n_s = rsh_s;
                lo_n_s = {a_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n_s = mul_hi_s;
            lo_n_s = mul_lo_s;
        end
`else
        hi_n_s = mul_hi_s;
        lo_n_s = mul_lo_s;
`endif
    end

    // Control FSM next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        y_d     = y_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    op_d = bus.op;
                    a_d  = bus.a;
                    b_d  = bus.b;
                    hi_d = {WIDTH{1'b0}};
                    if (op_is_iter(bus.op)) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(WIDTH);
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                        y_d     = bus.op[3] ? {WIDTH{1'b0}} : core_y_s;
                        zero_d  = (y_d == {WIDTH{1'b0}});
                        dz_d    = 1'b0;
                    end
                end else if ((state_q == ST_DONE) && bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                a_d   = lo_n_s;
                hi_d  = hi_n_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    y_d     = op_q[0] ? hi_n_s : lo_n_s;
                    zero_d  = (y_d == {WIDTH{1'b0}});
                    dz_d    = op_is_div(op_q) & (b_q == {WIDTH{1'b0}});
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 4'b0000;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            y_q     <= {WIDTH{1'b0}};
            zero_q  <= 1'b1;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
        end
    end

endmodule
